// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: merges ALU (src0) and load-unit (src1)
// results through one-entry holding registers into a single registered
// write port, and exports a busy mask for issue-stage scoreboarding.
// Optional feature macro: RF_WB_BYPASS_EN adds a two-port writeback bypass.
module rf_writeback_arbiter #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RBITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef RF_WB_BYPASS_EN
  input  logic [RBITS-1:0]        byp_rs_a,
  input  logic [RBITS-1:0]        byp_rs_b,
  output logic                    byp_hit_a,
  output logic                    byp_hit_b,
  output logic [XLEN-1:0]         byp_data_a,
  output logic [XLEN-1:0]         byp_data_b,
`endif
  input  logic                    s0_valid,
  output logic                    s0_ready,
  input  logic [RBITS-1:0]        s0_rd,
  input  logic [XLEN-1:0]         s0_data,
  input  logic                    s1_valid,
  output logic                    s1_ready,
  input  logic [RBITS-1:0]        s1_rd,
  input  logic [XLEN-1:0]         s1_data,
  output logic [RBITS-1:0]        wb_rd,
  output logic [XLEN-1:0]         wb_data,
  output logic [(2**RBITS)-1:0]   busy_mask
);

  localparam int unsigned NREG = 2 ** RBITS;

  // Holding registers, age flag and write-port registers
  logic             h0_v_q, h0_v_d;
  logic [RBITS-1:0] h0_rd_q, h0_rd_d;
  logic [XLEN-1:0]  h0_data_q, h0_data_d;
  logic             h1_v_q, h1_v_d;
  logic [RBITS-1:0] h1_rd_q, h1_rd_d;
  logic [XLEN-1:0]  h1_data_q, h1_data_d;
  logic             older_q, older_d;
  logic [RBITS-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;

  logic g0, g1;
  logic acc0, acc1;
  logic ld0, ld1;

  // Oldest-first grant between the two holding registers
  always_comb begin
    g0 = h0_v_q && (!h1_v_q || !older_q);
    g1 = h1_v_q && (!h0_v_q ||  older_q);
  end

  // Ready when the entry is empty or drains this cycle; never during reset
  always_comb begin
    s0_ready = rst_n && (!h0_v_q || g0);
    s1_ready = rst_n && (!h1_v_q || g1);
    acc0     = s0_valid && s0_ready;
    acc1     = s1_valid && s1_ready;
    ld0      = acc0 && (s0_rd != '0);
    ld1      = acc1 && (s1_rd != '0);
  end

  // Next-state: holding registers, age tracking and write port
  always_comb begin
    h0_v_d    = h0_v_q;
    h0_rd_d   = h0_rd_q;
    h0_data_d = h0_data_q;
    h1_v_d    = h1_v_q;
    h1_rd_d   = h1_rd_q;
    h1_data_d = h1_data_q;
    older_d   = older_q;
    wb_rd_d   = '0;
    wb_data_d = wb_data_q;

    if (g0) h0_v_d = 1'b0;
    if (ld0) begin
      h0_v_d    = 1'b1;
      h0_rd_d   = s0_rd;
      h0_data_d = s0_data;
    end

    if (g1) h1_v_d = 1'b0;
    if (ld1) begin
      h1_v_d    = 1'b1;
      h1_rd_d   = s1_rd;
      h1_data_d = s1_data;
    end

    // The entry that was not freshly loaded is the older one; tie goes to src0
    if (h0_v_d && h1_v_d) begin
      if (ld0 && ld1)  older_d = 1'b0;
      else if (ld0)    older_d = 1'b1;
      else if (ld1)    older_d = 1'b0;
    end

    if (g0) begin
      wb_rd_d   = h0_rd_q;
      wb_data_d = h0_data_q;
    end else if (g1) begin
      wb_rd_d   = h1_rd_q;
      wb_data_d = h1_data_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h0_v_q    <= 1'b0;
      h0_rd_q   <= '0;
      h0_data_q <= '0;
      h1_v_q    <= 1'b0;
      h1_rd_q   <= '0;
      h1_data_q <= '0;
      older_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      h0_v_q    <= h0_v_d;
      h0_rd_q   <= h0_rd_d;
      h0_data_q <= h0_data_d;
      h1_v_q    <= h1_v_d;
      h1_rd_q   <= h1_rd_d;
      h1_data_q <= h1_data_d;
      older_q   <= older_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

  // Busy mask: held destinations plus the one on the write port; r0 never busy
  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      busy_mask[r] = (h0_v_q && (h0_rd_q == RBITS'(r))) ||
                     (h1_v_q && (h1_rd_q == RBITS'(r))) ||
                     (wb_rd_q == RBITS'(r));
    end
  end

`ifdef RF_WB_BYPASS_EN
  // Forward the value the register file commits at the next edge
  always_comb begin
    byp_hit_a  = (byp_rs_a == wb_rd_q) && (wb_rd_q != '0);
    byp_hit_b  = (byp_rs_b == wb_rd_q) && (wb_rd_q != '0);
    byp_data_a = wb_data_q;
    byp_data_b = wb_data_q;
  end
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: a scoreboard queue of expected
// writes is filled as stimulus is driven and drained by a write-port monitor.
module tb_rf_writeback_arbiter;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RBITS = 5;

  logic             clk;
  logic             rst_n;
  logic             s0_valid, s0_ready;
  logic [RBITS-1:0] s0_rd;
  logic [XLEN-1:0]  s0_data;
  logic             s1_valid, s1_ready;
  logic [RBITS-1:0] s1_rd;
  logic [XLEN-1:0]  s1_data;
  logic [RBITS-1:0] wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [31:0]      busy_mask;
`ifdef RF_WB_BYPASS_EN
  logic [RBITS-1:0] byp_rs_a, byp_rs_b;
  logic             byp_hit_a, byp_hit_b;
  logic [XLEN-1:0]  byp_data_a, byp_data_b;
`endif

  rf_writeback_arbiter #(.XLEN(XLEN), .RBITS(RBITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RF_WB_BYPASS_EN
    .byp_rs_a  (byp_rs_a),
    .byp_rs_b  (byp_rs_b),
    .byp_hit_a (byp_hit_a),
    .byp_hit_b (byp_hit_b),
    .byp_data_a(byp_data_a),
    .byp_data_b(byp_data_b),
`endif
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s0_rd     (s0_rd),
    .s0_data   (s0_data),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .s1_rd     (s1_rd),
    .s1_data   (s1_data),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy_mask (busy_mask)
  );

  typedef struct {
    logic [RBITS-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_t;

  wb_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_writes = 0;
  bit  mon_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [RBITS-1:0] rd, input logic [XLEN-1:0] data);
    wb_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Write-port monitor: every non-zero wb_rd is one register-file write
  always @(negedge clk) begin
    if (mon_en && rst_n && (wb_rd != '0)) begin
      wb_t e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_write", 64'(wb_rd), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("wb_rd", 64'(wb_rd), 64'(e.rd));
        check_eq("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
  end

  initial begin
    int i0, i1, w0;
    logic a0, a1;

    rst_n = 1'b0;
    s0_valid = 1'b0; s0_rd = '0; s0_data = '0;
    s1_valid = 1'b0; s1_rd = '0; s1_data = '0;
`ifdef RF_WB_BYPASS_EN
    byp_rs_a = '0; byp_rs_b = '0;
`endif

    // Reset state; ready must stay low during reset even with valid asserted
    tick();
    s0_valid = 1'b1; s0_rd = 5'd4; s0_data = 32'hBAD0;
    s1_valid = 1'b1; s1_rd = 5'd6; s1_data = 32'hBAD1;
    #1;
    check_eq("rst_s0_ready", 64'(s0_ready), 64'(0));
    check_eq("rst_s1_ready", 64'(s1_ready), 64'(0));
    tick();
    check_eq("rst_wb_rd", 64'(wb_rd), 64'(0));
    check_eq("rst_wb_data", 64'(wb_data), 64'(0));
    check_eq("rst_busy", 64'(busy_mask), 64'(0));
    s0_valid = 1'b0; s1_valid = 1'b0;
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    check_eq("idle_s0_ready", 64'(s0_ready), 64'(1));
    tick();
    check_eq("post_rst_wb_rd", 64'(wb_rd), 64'(0));

    // T1: single ALU result, two-edge latency
    s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'h0000_00AA;
    push_exp(5'd5, 32'hAA);
    #1;
    check_eq("t1_s0_ready", 64'(s0_ready), 64'(1));
    tick();
    s0_valid = 1'b0;
    check_eq("t1_busy_held", 64'(busy_mask[5]), 64'(1));
    check_eq("t1_wb_not_yet", 64'(wb_rd), 64'(0));
    tick();
    check_eq("t1_wb_rd", 64'(wb_rd), 64'(5));
    check_eq("t1_busy_wb", 64'(busy_mask), 64'(32'h20));
    tick();
    check_eq("t1_wb_clear", 64'(wb_rd), 64'(0));
    check_eq("t1_busy_clear", 64'(busy_mask), 64'(0));
    check_eq("t1_wb_data_hold", 64'(wb_data), 64'(32'hAA));

    // T2: same rd from both sources in the same cycle, src0 first
    s0_valid = 1'b1; s0_rd = 5'd3; s0_data = 32'h11;
    s1_valid = 1'b1; s1_rd = 5'd3; s1_data = 32'h22;
    push_exp(5'd3, 32'h11);
    push_exp(5'd3, 32'h22);
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    check_eq("t2_s1_ready_low", 64'(s1_ready), 64'(0));
    check_eq("t2_s0_ready", 64'(s0_ready), 64'(1));
    check_eq("t2_busy", 64'(busy_mask), 64'(32'h8));
    tick();
    check_eq("t2_s1_ready_back", 64'(s1_ready), 64'(1));
    tick();
    tick();
    check_eq("t2_wb_clear", 64'(wb_rd), 64'(0));
    check_eq("t2_q_empty", 64'(exp_q.size()), 64'(0));

    // T3: both stream for 8 cycles; grants alternate after the initial tie
    for (int k = 0; k < 4; k++) begin
      push_exp(5'(8 + k), 32'h1000 + 32'(k));
      push_exp(5'(16 + k), 32'h2000 + 32'(k));
    end
    push_exp(5'd12, 32'h1004);
    i0 = 0; i1 = 0; w0 = n_writes;
    for (int c = 0; c < 8; c++) begin
      s0_valid = 1'b1; s0_rd = 5'(8 + i0);  s0_data = 32'h1000 + 32'(i0);
      s1_valid = 1'b1; s1_rd = 5'(16 + i1); s1_data = 32'h2000 + 32'(i1);
      #1;
      a0 = s0_ready; a1 = s1_ready;
      tick();
      i0 += int'(a0);
      i1 += int'(a1);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    tick(); tick(); tick();
    check_eq("t3_s0_accepted", 64'(i0), 64'(5));
    check_eq("t3_s1_accepted", 64'(i1), 64'(4));
    check_eq("t3_writes", 64'(n_writes - w0), 64'(9));
    check_eq("t3_q_empty", 64'(exp_q.size()), 64'(0));
    check_eq("t3_wb_clear", 64'(wb_rd), 64'(0));

    // T4: rd==0 result is accepted and dropped
    w0 = n_writes;
    s1_valid = 1'b1; s1_rd = 5'd0; s1_data = 32'hDEAD;
    #1;
    check_eq("t4_s1_ready", 64'(s1_ready), 64'(1));
    tick();
    s1_valid = 1'b0;
    check_eq("t4_busy", 64'(busy_mask), 64'(0));
    tick();
    check_eq("t4_wb_rd", 64'(wb_rd), 64'(0));
    tick();
    check_eq("t4_wb_rd_late", 64'(wb_rd), 64'(0));
    check_eq("t4_no_write", 64'(n_writes - w0), 64'(0));

    // T5: reset with both holding registers full discards everything
    s0_valid = 1'b1; s0_rd = 5'd20; s0_data = 32'h55;
    s1_valid = 1'b1; s1_rd = 5'd21; s1_data = 32'h66;
    tick();
    s0_valid = 1'b0; s1_valid = 1'b0;
    check_eq("t5_busy_full", 64'(busy_mask), 64'(32'h0030_0000));
    rst_n = 1'b0;
    #1;
    check_eq("t5_s0_ready_rst", 64'(s0_ready), 64'(0));
    check_eq("t5_s1_ready_rst", 64'(s1_ready), 64'(0));
    tick();
    rst_n = 1'b1;
    w0 = n_writes;
    check_eq("t5_wb_rd", 64'(wb_rd), 64'(0));
    check_eq("t5_wb_data", 64'(wb_data), 64'(0));
    check_eq("t5_busy", 64'(busy_mask), 64'(0));
    for (int c = 0; c < 4; c++) tick();
    check_eq("t5_no_stale", 64'(n_writes - w0), 64'(0));

`ifdef RF_WB_BYPASS_EN
    // T6: bypass sees the value on the write port
    s0_valid = 1'b1; s0_rd = 5'd7; s0_data = 32'h1234;
    push_exp(5'd7, 32'h1234);
    tick();
    s0_valid = 1'b0;
    tick();
    byp_rs_a = 5'd7; byp_rs_b = 5'd0;
    #1;
    check_eq("t6_hit_a", 64'(byp_hit_a), 64'(1));
    check_eq("t6_data_a", 64'(byp_data_a), 64'(32'h1234));
    check_eq("t6_hit_b", 64'(byp_hit_b), 64'(0));
    byp_rs_b = 5'd5;
    #1;
    check_eq("t6_miss_b", 64'(byp_hit_b), 64'(0));
    tick();
    check_eq("t6_no_hit_idle", 64'(byp_hit_a), 64'(0));
`endif

    tick();
    check_eq("final_q_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
